read_master_2d: RTL and testbench

- AXI4 full read master for the 2D DMA. It fetches an image window of `i_img_height` rows; each row is `i_img_width` bytes, and row starts are `i_img_stride` bytes apart, beginning at `i_src_addr`.
- Read beats are pushed into the shared data FIFO, which the 2D write master drains.
- It is the source-side counterpart of the destination write engine, and uses the same burst-splitting rules: 64 B max, row end, 4 KB boundary.

---
 rtl/dma_2d_pkg.sv | 19 +
 rtl/dma_burst_calc.sv | 29 ++
 rtl/read_master_2d.sv | 187 ++++++++++++++++++
 tb/tb_read_master_2d.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_2d_pkg.sv
// Shared definitions for the 2D DMA read and write masters: FSM encoding,
// AXI field constants and burst-splitting limits.
package dma_2d_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        AR_PHASE = 4'b0010,
        R_PHASE  = 4'b0100,
        NEXT     = 4'b1000
    } dma_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int MAX_BURST_BYTES = 64;
    localparam int PAGE_BYTES      = 4096;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizer: bytes = min(64, remaining row bytes, distance to next 4 KB page),
// plus the matching AXI length field (beats - 1) for 4-byte beats.
module dma_burst_calc
    import dma_2d_pkg::*;
(
    input  logic [31:0] cur_addr,
    input  logic [31:0] line_rem,
    output logic [6:0]  len_bytes,
    output logic [7:0]  arlen
);

    logic [31:0] boundary_dist;

    assign boundary_dist = ((cur_addr & ~32'(PAGE_BYTES - 1)) + 32'(PAGE_BYTES)) - cur_addr;

    // Both candidates are below 64 whenever they win, so the 7-bit slice is exact.
    always_comb begin
        len_bytes = 7'(MAX_BURST_BYTES);
        if ((line_rem < 32'(MAX_BURST_BYTES)) || (boundary_dist < 32'(MAX_BURST_BYTES))) begin
            if (line_rem < boundary_dist)
                len_bytes = line_rem[6:0];
            else
                len_bytes = boundary_dist[6:0];
        end
    end

    assign arlen = ({1'b0, len_bytes} >> 2) - 8'd1;

endmodule

// File: rtl/read_master_2d.sv
// AXI4 read master for the 2D DMA: walks a strided image window in bursts and
// pushes every read beat into the shared data FIFO. Optional: RD_RRESP_CHECK_EN.
module read_master_2d
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [31:0]                   i_src_addr,
    input  logic [31:0]                   i_img_width,
    input  logic [31:0]                   i_img_height,
    input  logic [31:0]                   i_img_stride,
    output logic                          o_read_done,
    output logic                          o_busy,
    output logic                          o_read_error,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wr_en,
    output logic [31:0]                   o_fifo_wdata,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    dma_state_t  state;
    logic [31:0] width_q;
    logic [31:0] height_q;
    logic [31:0] stride_q;
    logic [31:0] cur_addr;
    logic [31:0] line_start;
    logic [31:0] line_bytes;
    logic [31:0] line_cnt;
    logic [6:0]  burst_bytes;
    logic [7:0]  beat_cnt;
    logic        arvalid_q;
    logic        done_q;

    logic [31:0] line_rem;
    logic [6:0]  calc_bytes;
    logic [7:0]  calc_arlen;
    logic        r_hs;
    logic        row_end;
    logic        last_row;
    logic        err_stop;
    logic [31:0] next_line_start;
    logic [7:0]  burst_beats;

    assign line_rem = width_q - line_bytes;

    dma_burst_calc u_burst_calc (
        .cur_addr  (cur_addr),
        .line_rem  (line_rem),
        .len_bytes (calc_bytes),
        .arlen     (calc_arlen)
    );

    assign m_axi_araddr  = cur_addr[C_M_AXI_ADDR_WIDTH-1:0];
    assign m_axi_arlen   = calc_arlen;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arvalid = arvalid_q;

    // The FIFO push is the R handshake itself, so a stalled beat is never pushed twice.
    assign m_axi_rready = (state == R_PHASE) && !i_fifo_full;
    assign r_hs         = m_axi_rready && m_axi_rvalid;
    assign o_fifo_wr_en = r_hs;
    assign o_fifo_wdata = m_axi_rdata;

    assign o_busy      = (state != IDLE);
    assign o_read_done = done_q;

    assign row_end         = (line_bytes + {25'd0, burst_bytes}) >= width_q;
    assign last_row        = row_end && (line_cnt == (height_q - 32'd1));
    assign next_line_start = line_start + stride_q;
    assign burst_beats     = {1'b0, burst_bytes} >> 2;

`ifdef RD_RRESP_CHECK_EN
    logic read_error_q;
    assign o_read_error = read_error_q;
    assign err_stop     = read_error_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
    assign o_read_error = 1'b0;
    assign err_stop     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            stride_q    <= '0;
            cur_addr    <= '0;
            line_start  <= '0;
            line_bytes  <= '0;
            line_cnt    <= '0;
            burst_bytes <= '0;
            beat_cnt    <= '0;
            arvalid_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef RD_RRESP_CHECK_EN
            read_error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        width_q    <= i_img_width;
                        height_q   <= i_img_height;
                        stride_q   <= i_img_stride;
                        cur_addr   <= i_src_addr;
                        line_start <= i_src_addr;
                        line_bytes <= '0;
                        line_cnt   <= '0;
`ifdef RD_RRESP_CHECK_EN
                        read_error_q <= 1'b0;
`endif
                        if ((i_img_width == 32'd0) || (i_img_height == 32'd0)) begin
                            done_q <= 1'b1;
                        end else begin
                            done_q    <= 1'b0;
                            arvalid_q <= 1'b1;
                            state     <= AR_PHASE;
                        end
                    end
                end
                AR_PHASE: begin
                    if (m_axi_arready) begin
                        arvalid_q   <= 1'b0;
                        burst_bytes <= calc_bytes;
                        beat_cnt    <= '0;
                        state       <= R_PHASE;
                    end
                end
                R_PHASE: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
`ifdef RD_RRESP_CHECK_EN
                        if (m_axi_rresp != RESP_OKAY)
                            read_error_q <= 1'b1;
`endif
                        if (m_axi_rlast)
                            state <= NEXT;
                    end
                end
                NEXT: begin
                    if (row_end) begin
                        line_start <= next_line_start;
                        cur_addr   <= next_line_start;
                        line_bytes <= '0;
                        line_cnt   <= line_cnt + 32'd1;
                    end else begin
                        cur_addr   <= cur_addr + {25'd0, burst_bytes};
                        line_bytes <= line_bytes + {25'd0, burst_bytes};
                    end
                    if (last_row || err_stop) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        arvalid_q <= 1'b1;
                        state     <= AR_PHASE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // rlast is trusted for control; the beat counter only cross-checks the slave.
    assert property (@(posedge clk) disable iff (reset)
        (r_hs && m_axi_rlast) |-> (beat_cnt == (burst_beats - 8'd1)));

endmodule

// File: tb/tb_read_master_2d.sv
// Directed bench for read_master_2d with a simple AXI read slave model.
module tb_read_master_2d;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_src_addr, i_img_width, i_img_height, i_img_stride;
    logic        o_read_done, o_busy, o_read_error;
    logic        i_fifo_full;
    logic        o_fifo_wr_en;
    logic [31:0] o_fifo_wdata;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    read_master_2d dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_src_addr    (i_src_addr),
        .i_img_width   (i_img_width),
        .i_img_height  (i_img_height),
        .i_img_stride  (i_img_stride),
        .o_read_done   (o_read_done),
        .o_busy        (o_busy),
        .o_read_error  (o_read_error),
        .i_fifo_full   (i_fifo_full),
        .o_fifo_wr_en  (o_fifo_wr_en),
        .o_fifo_wdata  (o_fifo_wdata),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [31:0] push_q[$];
    int ar_delay  = 0;
    int err_burst = -1;
    int err_beat  = -1;
    int burst_no  = 0;

    // Slave: drives at the falling edge, samples handshakes 1 time unit later.
    initial begin : slave
        logic [31:0] b_base, cap_addr;
        logic [7:0]  cap_len;
        int b_beats, b_idx, ar_wait;
        bit b_act, ar_hs, r_hs;
        b_base = 0; cap_addr = 0; cap_len = 0;
        b_beats = 0; b_idx = 0; ar_wait = 0;
        b_act = 0; ar_hs = 0; r_hs = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
        m_axi_rresp = 0; m_axi_rlast = 0;
        forever begin
            @(negedge clk);
            if (ar_hs) begin
                ar_addr_q.push_back(cap_addr);
                ar_len_q.push_back(cap_len);
                b_base = cap_addr; b_beats = int'(cap_len) + 1; b_idx = 0;
                b_act = 1; ar_wait = 0;
            end
            if (r_hs) begin
                b_idx++;
                if (b_idx == b_beats) begin
                    b_act = 0;
                    burst_no++;
                end
            end
            if (reset) begin
                b_act = 0; ar_wait = 0; burst_no = 0;
            end
            if (m_axi_arvalid && !b_act) begin
                m_axi_arready = (ar_wait >= ar_delay);
                ar_wait++;
            end else begin
                m_axi_arready = 0;
            end
            m_axi_rvalid = b_act;
            m_axi_rdata  = b_act ? mem(b_base + 32'(4 * b_idx)) : 32'h0;
            m_axi_rlast  = b_act && (b_idx == b_beats - 1);
            m_axi_rresp  = (b_act && burst_no == err_burst && b_idx == err_beat) ? 2'b10 : 2'b00;
            #1;
            ar_hs    = m_axi_arvalid && m_axi_arready;
            cap_addr = m_axi_araddr;
            cap_len  = m_axi_arlen;
            r_hs     = m_axi_rvalid && m_axi_rready;
            if (o_fifo_wr_en) push_q.push_back(o_fifo_wdata);
        end
    end

    task automatic run_start(input logic [31:0] src, w, h, s);
        @(negedge clk);
        push_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
        burst_no = 0;
        i_src_addr = src; i_img_width = w; i_img_height = h; i_img_stride = s;
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        #2;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int c = 0;
        while (!o_read_done && c < maxc) begin
            @(negedge clk); #2; c++;
        end
        chk({tag, "_done"}, o_read_done, 1);
        chk({tag, "_idle"}, o_busy, 0);
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
        if (idx < ar_addr_q.size()) begin
            chk($sformatf("%s_araddr%0d", tag, idx), ar_addr_q[idx], a);
            chk($sformatf("%s_arlen%0d", tag, idx), 32'(ar_len_q[idx]), 32'(l));
        end
    endtask

    task automatic check_pushes(input string tag, input logic [31:0] src, w, h, s);
        int k = 0;
        chk({tag, "_push_cnt"}, 32'(push_q.size()), (w / 4) * h);
        for (int r = 0; r < int'(h); r++) begin
            for (int b = 0; b < int'(w); b += 4) begin
                if (k < push_q.size())
                    chk($sformatf("%s_data%0d", tag, k), push_q[k], mem(src + 32'(r) * s + 32'(b)));
                k++;
            end
        end
    endtask

    initial begin : main
        int c, n0;
        reset = 1; i_start = 0; i_fifo_full = 0;
        i_src_addr = 0; i_img_width = 0; i_img_height = 0; i_img_stride = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_read_done, 0);
        chk("rst_err", o_read_error, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_wr_en", o_fifo_wr_en, 0);
        @(negedge clk);
        reset = 0;

        // Single aligned 64 B row.
        run_start(32'h1000, 64, 1, 64);
        chk("t1_busy", o_busy, 1);
        chk("t1_arvalid", m_axi_arvalid, 1);
        chk("t1_araddr", m_axi_araddr, 32'h1000);
        chk("t1_arlen", 32'(m_axi_arlen), 15);
        chk("t1_arsize", 32'(m_axi_arsize), 2);
        chk("t1_arburst", 32'(m_axi_arburst), 1);
        wait_done("t1", 500);
        chk("t1_ar_cnt", 32'(ar_addr_q.size()), 1);
        check_ar("t1", 0, 32'h1000, 15);
        check_pushes("t1", 32'h1000, 64, 1, 64);

        // Row straddling a 4 KB page.
        run_start(32'h0FF0, 64, 1, 64);
        wait_done("t2", 500);
        chk("t2_ar_cnt", 32'(ar_addr_q.size()), 2);
        check_ar("t2", 0, 32'h0FF0, 3);
        check_ar("t2", 1, 32'h1000, 11);
        check_pushes("t2", 32'h0FF0, 64, 1, 64);

        // Three 96 B rows, stride 256, slow arready.
        ar_delay = 2;
        run_start(32'h2000, 96, 3, 256);
        wait_done("t3", 2000);
        ar_delay = 0;
        chk("t3_ar_cnt", 32'(ar_addr_q.size()), 6);
        check_ar("t3", 0, 32'h2000, 15);
        check_ar("t3", 1, 32'h2040, 7);
        check_ar("t3", 2, 32'h2100, 15);
        check_ar("t3", 3, 32'h2140, 7);
        check_ar("t3", 4, 32'h2200, 15);
        check_ar("t3", 5, 32'h2240, 7);
        check_pushes("t3", 32'h2000, 96, 3, 256);

        // FIFO full for 5 cycles in the middle of a burst.
        run_start(32'h3000, 64, 1, 64);
        c = 0;
        while (push_q.size() < 5 && c < 200) begin
            @(negedge clk); #2; c++;
        end
        chk("t4_progress", 32'(push_q.size() >= 5), 1);
        @(negedge clk);
        n0 = push_q.size();
        i_fifo_full = 1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t4_stall_rready", m_axi_rready, 0);
            chk("t4_stall_push", o_fifo_wr_en, 0);
            @(negedge clk);
        end
        i_fifo_full = 0;
        chk("t4_stall_nopush", 32'(push_q.size()), 32'(n0));
        wait_done("t4", 500);
        chk("t4_ar_cnt", 32'(ar_addr_q.size()), 1);
        check_pushes("t4", 32'h3000, 64, 1, 64);

        // Degenerate geometry completes without any AR.
        run_start(32'h1000, 0, 5, 64);
        chk("t5w_done", o_read_done, 1);
        chk("t5w_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("t5w_ar_cnt", 32'(ar_addr_q.size()), 0);
        run_start(32'h1000, 64, 0, 64);
        chk("t5h_done", o_read_done, 1);
        chk("t5h_busy", o_busy, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("t5h_ar_cnt", 32'(ar_addr_q.size()), 0);

        // SLVERR on the third beat of the first burst of a 128 B row.
        err_burst = 0; err_beat = 2;
        run_start(32'h4000, 128, 1, 128);
        wait_done("t6", 1000);
        err_burst = -1; err_beat = -1;
`ifdef RD_RRESP_CHECK_EN
        chk("t6_err", o_read_error, 1);
        chk("t6_ar_cnt", 32'(ar_addr_q.size()), 1);
        check_ar("t6", 0, 32'h4000, 15);
        check_pushes("t6", 32'h4000, 64, 1, 64);
`else
        chk("t6_err", o_read_error, 0);
        chk("t6_ar_cnt", 32'(ar_addr_q.size()), 2);
        check_ar("t6", 0, 32'h4000, 15);
        check_ar("t6", 1, 32'h4040, 15);
        check_pushes("t6", 32'h4000, 128, 1, 128);
`endif

        // Reset in the middle of the data phase.
        run_start(32'h5000, 64, 1, 64);
        c = 0;
        while (push_q.size() < 3 && c < 200) begin
            @(negedge clk); #2; c++;
        end
        chk("t7_progress", 32'(push_q.size() >= 3), 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        #2;
        chk("t7_busy", o_busy, 0);
        chk("t7_arvalid", m_axi_arvalid, 0);
        chk("t7_rready", m_axi_rready, 0);
        chk("t7_wr_en", o_fifo_wr_en, 0);
        chk("t7_done", o_read_done, 0);
        chk("t7_err", o_read_error, 0);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
